// File: rtl/pat_imem_pkg.sv
// Shared constants and types for the instruction-memory loader.
// Frame length depends on IMEM_LOADER_CHECKSUM_EN (7 bytes, or 8 with a trailing XOR byte).
package pat_imem_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DATA_W = 40;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int FRAME_BYTES = 8;
`else
    localparam int FRAME_BYTES = 7;
`endif

    // Byte-counter value at which the final byte of a frame arrives
    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_READY = 2'd2,
        ST_WRITE = 2'd3
    } loader_state_t;

    // Saturating increment for the 11-bit committed-word counter
    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

endpackage

// File: rtl/edge_det.sv
// One-bit registered rising-edge detector: o_rise = level & ~previous level.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    // Remember last cycle's level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles byte frames from port A
// (addr_hi, addr_lo, d4..d0, MSB-first) and commits one word per write_req edge.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
    import pat_imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clk_int,
    input  logic              reset,
    input  logic              load_mode,
    input  logic [7:0]        byte_in,
    input  logic              byte_clk,
    input  logic              write_req,
    output logic [ADDR_W-1:0] imem_write_adr,
    output logic [DATA_W-1:0] imem_in,
    output logic              imem_write_en,
    output logic              loader_busy,
    output logic              frame_error,
    output logic [10:0]       words_written
);

    // Only the address bits and data are kept; addr_hi's unused upper bits
    // are judged when the first byte arrives and remembered in r_hi_bad.
    localparam int WORD_W = ADDR_W + DATA_W;

    logic w_byte_rise;
    logic w_wreq_rise;
    logic w_lm_rise;
    logic w_take_data;
    logic w_bad_frame;

    loader_state_t     r_state;
    logic [2:0]        r_cnt;
    logic [WORD_W-1:0] r_frame;
    logic              r_hi_bad;
    logic [ADDR_W-1:0] r_adr;
    logic [DATA_W-1:0] r_dat;
    logic              r_wen;
    logic              r_busy;
    logic              r_err;
    logic [10:0]       r_words;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    edge_det u_byte_edge (
        .clk     (clk_int),
        .rst     (reset),
        .i_level (byte_clk),
        .o_rise  (w_byte_rise)
    );

    edge_det u_wreq_edge (
        .clk     (clk_int),
        .rst     (reset),
        .i_level (write_req),
        .o_rise  (w_wreq_rise)
    );

    edge_det u_lm_edge (
        .clk     (clk_int),
        .rst     (reset),
        .i_level (load_mode),
        .o_rise  (w_lm_rise)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    // The checksum byte is compared, never shifted into the word
    assign w_take_data = (r_cnt != LAST_IDX);
    // XOR of all eight bytes is zero for a good frame
    assign w_bad_frame = r_hi_bad | ((r_csum ^ byte_in) != 8'h00);
`else
    assign w_take_data = 1'b1;
    assign w_bad_frame = r_hi_bad;
`endif

    // Write strobe is dropped immediately when load mode is left
    assign imem_write_en  = r_wen & load_mode;
    assign imem_write_adr = r_adr;
    assign imem_in        = r_dat;
    assign loader_busy    = r_busy;
    assign frame_error    = r_err;
    assign words_written  = r_words;

    // Protocol FSM, frame shifter and registered write-port outputs
    always_ff @(posedge clk_int) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_frame  <= '0;
            r_hi_bad <= 1'b0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_wen    <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum   <= '0;
`endif
        end else begin
            r_wen <= 1'b0;
            // Error clear on load_mode entry; a same-cycle error still wins below
            if (w_lm_rise) begin
                r_err <= 1'b0;
            end
            if (!load_mode) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else if (w_byte_rise && w_wreq_rise) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
                r_err   <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_wreq_rise) begin
                            r_err <= 1'b1;
                        end else if (w_byte_rise) begin
                            r_frame  <= {r_frame[WORD_W-9:0], byte_in};
                            r_hi_bad <= |byte_in[7:ADDR_W-8];
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_csum   <= byte_in;
`endif
                            r_cnt    <= 3'd1;
                            r_state  <= ST_SHIFT;
                            r_busy   <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (w_wreq_rise) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end else if (w_byte_rise) begin
                            if (w_take_data) begin
                                r_frame <= {r_frame[WORD_W-9:0], byte_in};
                            end
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_csum <= r_csum ^ byte_in;
`endif
                            if (r_cnt == LAST_IDX) begin
                                r_cnt <= '0;
                                if (w_bad_frame) begin
                                    r_state <= ST_IDLE;
                                    r_busy  <= 1'b0;
                                    r_err   <= 1'b1;
                                end else begin
                                    r_state <= ST_READY;
                                end
                            end else begin
                                r_cnt <= r_cnt + 3'd1;
                            end
                        end
                    end
                    ST_READY: begin
                        if (w_byte_rise) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end else if (w_wreq_rise) begin
                            r_adr   <= r_frame[DATA_W +: ADDR_W];
                            r_dat   <= r_frame[DATA_W-1:0];
                            r_wen   <= 1'b1;
                            r_state <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Count words actually strobed into the core, saturating at 2047
    always_ff @(posedge clk_int) begin
        if (reset) begin
            r_words <= '0;
        end else if (imem_write_en) begin
            r_words <= sat_inc11(r_words);
        end
    end

endmodule
